// File: rtl/dmem_responder.sv
// dmem_responder: req/ready data memory with wait states, fault flag and committed-store tracking.
// Optional macro DMEM_WAIT_EN builds the WAIT state and wait counter; without it every accept responds next cycle.
module dmem_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        err,
   output logic [31:0] rdata,
   output logic [15:0] store_count,
   output logic [31:0] last_store_adr
);
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] ADR_LIMIT = 32'(4 * DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RESP = 2'd2;

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || WAIT_CYCLES < 0) begin : g_cfg_check
      $error("dmem_responder: DEPTH must be a power of two >= 4 and WAIT_CYCLES >= 0");
   end

   function automatic logic adr_fault(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= ADR_LIMIT);
   endfunction

   logic [1:0]    state;
   logic [31:0]   mem [DEPTH];
   logic          commit;
   logic          c_we;
   logic [31:0]   c_adr;
   logic [31:0]   c_wdata;
   logic          c_fault;
   logic [AW-1:0] c_idx;

`ifdef DMEM_WAIT_EN
   localparam logic [1:0]       S_WAIT   = 2'd1;
   localparam int               CNT_W    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

   logic [CNT_W-1:0] wait_cnt;
   logic             lat_we;
   logic [31:0]      lat_adr;
   logic [31:0]      lat_wdata;

   // The commit edge uses live inputs when it is also the accept edge, else the latched request.
   always_comb begin
      commit  = 1'b0;
      c_we    = we;
      c_adr   = adr;
      c_wdata = wdata;
      if (state == S_IDLE) begin
         commit = req && (WAIT_CYCLES == 0);
      end else if (state == S_WAIT) begin
         commit  = (wait_cnt == CNT_W'(1));
         c_we    = lat_we;
         c_adr   = lat_adr;
         c_wdata = lat_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (req) begin
               wait_cnt <= CNT_LOAD;
               state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - CNT_W'(1);
               if (wait_cnt == CNT_W'(1)) state <= S_RESP;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && req) begin
         lat_we    <= we;
         lat_adr   <= adr;
         lat_wdata <= wdata;
      end
   end
`else
   always_comb begin
      commit  = (state == S_IDLE) && req;
      c_we    = we;
      c_adr   = adr;
      c_wdata = wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (req) state <= S_RESP;
            default: state <= S_IDLE;
         endcase
      end
   end
`endif

   assign c_fault = adr_fault(c_adr);
   assign c_idx   = c_adr[AW+1:2];
   assign ready   = (state == S_RESP);

   // Reset on the commit edge drops the store.
   always_ff @(posedge clk) begin
      if (reset && commit && !c_fault && c_we) mem[c_idx] <= c_wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         err            <= 1'b0;
         rdata          <= '0;
         store_count    <= '0;
         last_store_adr <= '0;
      end else if (commit) begin
         err   <= c_fault;
         rdata <= (c_fault || c_we) ? 32'd0 : mem[c_idx];
         if (!c_fault && c_we) begin
            store_count    <= store_count + 16'd1;
            last_store_adr <= c_adr;
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences and a randomized model check.
module tb_dmem_responder;
   localparam int DEPTH       = 64;
   localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_EN
   localparam int EFF_WAIT = WAIT_CYCLES;
`else
   localparam int EFF_WAIT = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] adr = '0;
   logic [31:0] wdata = '0;
   logic        ready;
   logic        err;
   logic [31:0] rdata;
   logic [15:0] store_count;
   logic [31:0] last_store_adr;

   int tests = 0;
   int fails = 0;

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .adr(adr), .wdata(wdata),
      .ready(ready), .err(err), .rdata(rdata), .store_count(store_count),
      .last_store_adr(last_store_adr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Issues one request from IDLE, waits (bounded) for ready, returns err/rdata, ends back in IDLE.
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic e, output logic [31:0] rd);
      int lat;
      req = 1'b1; we = w; adr = a; wdata = d;
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0; adr = '0; wdata = '0;
      lat = 0;
      while (!ready && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(EFF_WAIT));
      e  = err;
      rd = rdata;
      @(posedge clk); #1;
      chk("ready_one_cycle", 32'(ready), 32'd0);
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic        e;
      logic [31:0] rd;
      logic [15:0] cnt;
      logic [31:0] last;
   } vec_t;

   vec_t        vecs [13];
   logic        e;
   logic [31:0] rd;
   logic        exp_r;

   logic [31:0] mmem  [DEPTH];
   bit          known [DEPTH];
   logic [15:0] m_cnt;
   logic [31:0] m_last;

   initial begin
      vecs[0]  = '{1'b1, 32'd84,         32'd4,          1'b0, 32'd0,          16'd1, 32'd84};
      vecs[1]  = '{1'b1, 32'd80,         32'd7,          1'b0, 32'd0,          16'd2, 32'd80};
      vecs[2]  = '{1'b0, 32'd80,         32'd0,          1'b0, 32'd7,          16'd2, 32'd80};
      vecs[3]  = '{1'b0, 32'd84,         32'd0,          1'b0, 32'd4,          16'd2, 32'd80};
      vecs[4]  = '{1'b1, 32'd86,         32'd99,         1'b1, 32'd0,          16'd2, 32'd80};
      vecs[5]  = '{1'b0, 32'd256,        32'd0,          1'b1, 32'd0,          16'd2, 32'd80};
      vecs[6]  = '{1'b0, 32'd84,         32'd0,          1'b0, 32'd4,          16'd2, 32'd80};
      vecs[7]  = '{1'b1, 32'd0,          32'hDEADBEEF,   1'b0, 32'd0,          16'd3, 32'd0};
      vecs[8]  = '{1'b0, 32'd0,          32'd0,          1'b0, 32'hDEADBEEF,   16'd3, 32'd0};
      vecs[9]  = '{1'b1, 32'd252,        32'h12345678,   1'b0, 32'd0,          16'd4, 32'd252};
      vecs[10] = '{1'b0, 32'd252,        32'd0,          1'b0, 32'h12345678,   16'd4, 32'd252};
      vecs[11] = '{1'b0, 32'd253,        32'd0,          1'b1, 32'd0,          16'd4, 32'd252};
      vecs[12] = '{1'b0, 32'hFFFFFFFC,   32'd0,          1'b1, 32'd0,          16'd4, 32'd252};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_err",   32'(err),   32'd0);
      chk("rst_rdata", rdata,      32'd0);
      chk("rst_count", 32'(store_count), 32'd0);
      chk("rst_last",  last_store_adr,   32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         txn(vecs[i].w, vecs[i].a, vecs[i].d, e, rd);
         chk($sformatf("vec%0d_err", i),   32'(e),  32'(vecs[i].e));
         chk($sformatf("vec%0d_rdata", i), rd,      vecs[i].rd);
         chk($sformatf("vec%0d_count", i), 32'(store_count), 32'(vecs[i].cnt));
         chk($sformatf("vec%0d_last", i),  last_store_adr,   vecs[i].last);
      end

      // req held high: one response every EFF_WAIT+2 cycles, never back to back.
      req = 1'b1; we = 1'b0; adr = 32'd80;
      for (int i = 1; i <= 3 * (EFF_WAIT + 2); i++) begin
         @(posedge clk); #1;
         exp_r = (i >= 1 + EFF_WAIT) && (((i - 1 - EFF_WAIT) % (EFF_WAIT + 2)) == 0);
         chk($sformatf("held_ready%0d", i), 32'(ready), 32'(exp_r));
         if (exp_r) chk("held_rdata", rdata, 32'd7);
      end
      req = 1'b0; adr = '0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("idle_ready", 32'(ready), 32'd0);
         chk("rdata_hold", rdata, 32'd7);
      end

      // Reset restores output values; a store interrupted by reset is lost.
      txn(1'b1, 32'd84, 32'h11, e, rd);
      txn(1'b0, 32'd84, 32'd0, e, rd);
      chk("pre_reset_load", rd, 32'h11);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_rdata", rdata, 32'd0);
      chk("mid_rst_count", 32'(store_count), 32'd0);
      chk("mid_rst_last",  last_store_adr,   32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      req = 1'b1; we = 1'b1; adr = 32'd84; wdata = 32'h22;
      if (EFF_WAIT == 0) begin
         reset = 1'b0;
         @(posedge clk); #1;
         req = 1'b0; we = 1'b0; adr = '0; wdata = '0;
      end else begin
         @(posedge clk); #1;
         req = 1'b0; we = 1'b0; adr = '0; wdata = '0;
         reset = 1'b0;
         @(posedge clk); #1;
      end
      chk("abort_ready", 32'(ready), 32'd0);
      chk("abort_err",   32'(err),   32'd0);
      chk("abort_count", 32'(store_count), 32'd0);
      chk("abort_last",  last_store_adr,   32'd0);
      reset = 1'b1;
      repeat (EFF_WAIT + 2) begin
         @(posedge clk); #1;
         chk("abort_no_resp", 32'(ready), 32'd0);
      end
      txn(1'b0, 32'd84, 32'd0, e, rd);
      chk("abort_load_old", rd, 32'h11);
      chk("abort_err2", 32'(e), 32'd0);
      chk("abort_count2", 32'(store_count), 32'd0);

      // Randomized traffic against a word-array reference model.
      m_cnt  = 16'd0;
      m_last = 32'd0;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
      for (int n = 0; n < 200; n++) begin
         logic        w, fault, rd_known;
         logic [31:0] a, d, exp_rd;
         int          sel, idx;
         sel = int'($urandom_range(0, 9));
         if (sel <= 6)      a = $urandom_range(0, 15) * 4;
         else if (sel == 7) a = $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
         else if (sel == 8) a = 32'(4 * DEPTH) + $urandom_range(0, 1000) * 4;
         else               a = $urandom;
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         fault = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
         idx = fault ? 0 : int'(a / 4);
         rd_known = 1'b1;
         exp_rd = 32'd0;
         if (!fault && !w) begin
            rd_known = known[idx];
            exp_rd   = mmem[idx];
         end
         txn(w, a, d, e, rd);
         if (!fault && w) begin
            mmem[idx]  = d;
            known[idx] = 1'b1;
            m_cnt      = m_cnt + 16'd1;
            m_last     = a;
         end
         chk("rnd_err",   32'(e), 32'(fault));
         if (rd_known) chk("rnd_rdata", rd, exp_rd);
         chk("rnd_count", 32'(store_count), 32'(m_cnt));
         chk("rnd_last",  last_store_adr,   m_last);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            chk("rnd_idle_ready", 32'(ready), 32'd0);
            if (rd_known) chk("rnd_rdata_hold", rdata, exp_rd);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
